// File: rtl/afifo_pkg.sv
// afifo_pkg: Gray-code conversion and sizing helpers shared by both FIFO controllers.
// Conversions work on zero-extended operands, so any pointer width up to PW fits.
package afifo_pkg;
  localparam int PW = 32;
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/afifo_sync.sv
// afifo_sync: WIDTH x STAGES clock-domain-crossing flop chain with async active-low reset.
module afifo_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [STAGES-1:0][WIDTH-1:0] s_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= '0;
    else s_q <= {s_q[STAGES-2:0], d_i};
  assign q_o = s_q[STAGES-1];
endmodule

// File: rtl/afifo_wr_ctrl.sv
// afifo_wr_ctrl: write-domain controller of the dual-clock FIFO (pointers, full, level).
// Optional AFIFO_WR_ERRCNT_EN adds a saturating 16-bit overflow counter on port ovf_cnt.
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int DATA_DEPTH   = 64,
  parameter  int AFULL_THRESH = 56,
  parameter  int SYNC_STAGES  = 2,
  localparam int AW           = addr_width(DATA_DEPTH)
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic [AW:0]           rd_ptr_gray_i,
  output logic [AW:0]           wr_ptr_gray_o,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  full,
  output logic                  almost_full,
  output logic [AW:0]           wr_level,
  output logic                  overflow
`ifdef AFIFO_WR_ERRCNT_EN
  , output logic [15:0]         ovf_cnt
`endif
);
  localparam logic [AW:0] AFT = (AW+1)'(AFULL_THRESH);
  logic [AW:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d, rd_sync, rd_bin_s;
  logic [PW-1:0] rd_bin_w, wr_gray_w;
  logic rst_done_q, overflow_q, accept, unused_hi;
  afifo_sync #(.WIDTH(AW+1), .STAGES(SYNC_STAGES)) u_rd_sync (
    .clk  (wr_clk),
    .rst_n(wr_rst_n),
    .d_i  (rd_ptr_gray_i),
    .q_o  (rd_sync)
  );
  always_comb begin
    rd_bin_w  = gray2bin(PW'(rd_sync));
    rd_bin_s  = rd_bin_w[AW:0];
    full      = wr_gray_q == {~rd_sync[AW:AW-1], rd_sync[AW-2:0]};
    wr_ready  = rst_done_q & ~full;
    accept    = wr_valid & wr_ready;
    wr_bin_d  = wr_bin_q + (AW+1)'(accept);
    wr_gray_w = bin2gray(PW'(wr_bin_d));
    wr_gray_d = wr_gray_w[AW:0];
    unused_hi = ^{rd_bin_w[PW-1:AW+1], wr_gray_w[PW-1:AW+1]};
  end
  assign mem_we        = accept;
  assign mem_waddr     = wr_bin_q[AW-1:0];
  assign mem_wdata     = wr_data;
  assign wr_level      = wr_bin_q - rd_bin_s;
  assign almost_full   = wr_level >= AFT;
  assign wr_ptr_gray_o = wr_gray_q;
  assign overflow      = overflow_q;
  // Gray pointer is re-registered every cycle so the read domain only ever sees single-bit steps
  always_ff @(posedge wr_clk or negedge wr_rst_n)
    if (!wr_rst_n) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      rst_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      rst_done_q <= 1'b1;
      overflow_q <= wr_valid & rst_done_q & full;
    end
`ifdef AFIFO_WR_ERRCNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  assign ovf_cnt_d = ovf_cnt_q + 16'(overflow_q & ~&ovf_cnt_q);
  always_ff @(posedge wr_clk or negedge wr_rst_n)
    if (!wr_rst_n) ovf_cnt_q <= '0;
    else ovf_cnt_q <= ovf_cnt_d;
  assign ovf_cnt = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// tb_afifo_wr_ctrl: directed table plus randomized run against an occupancy-count model.
module tb_afifo_wr_ctrl;
  localparam int AW = 6, D = 64, S = 2, AF = 56;
  logic wr_clk = 0, wr_rst_n = 0, wr_valid = 0;
  logic [7:0] wr_data = 0;
  logic [AW:0] rd_ptr_gray_i = 0;
  logic wr_ready, mem_we, full, almost_full, overflow;
  logic [AW:0] wr_ptr_gray_o, wr_level;
  logic [AW-1:0] mem_waddr;
  logic [7:0] mem_wdata;
`ifdef AFIFO_WR_ERRCNT_EN
  logic [15:0] ovf_cnt;
`endif

  afifo_wr_ctrl #(.DATA_WIDTH(8), .DATA_DEPTH(D), .AFULL_THRESH(AF), .SYNC_STAGES(S)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_ptr_gray_i(rd_ptr_gray_i), .wr_ptr_gray_o(wr_ptr_gray_o),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
`ifdef AFIFO_WR_ERRCNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int n_chk = 0, n_fail = 0;
  int wr_cnt, eocnt, tot_ovf, wraps, full_seen;
  int rdp[S];
  bit rdone, eovf;
  logic [AW:0] prev_g;

  typedef struct {
    int n; bit v; int rdb; int lvl; bit f; bit af; bit rdy; bit ovf; int waddr; int gr;
  } seg_t;
  seg_t tbl[6];

  function automatic logic [AW:0] g(input int b);
    logic [AW:0] x;
    x = b[AW:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input longint a, input longint e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic model_reset;
    wr_cnt = 0; eocnt = 0; rdone = 0; eovf = 0; prev_g = 0;
    for (int i = 0; i < S; i++) rdp[i] = 0;
  endtask

  task automatic chk_zero;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_full", full, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_wr_level", wr_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wr_ptr_gray", wr_ptr_gray_o, 0);
`ifdef AFIFO_WR_ERRCNT_EN
    chk("rst_ovf_cnt", ovf_cnt, 0);
`endif
  endtask

  // One cycle: drive at negedge, check against the model, then advance across the posedge.
  task automatic cyc(input bit v, input int rdb);
    int rs, lvl;
    bit fe, re, acc;
    logic [7:0] d;
    d = 8'($urandom);
    wr_valid = v; wr_data = d; rd_ptr_gray_i = g(rdb);
    #1;
    rs = rdp[S-1];
    lvl = wr_cnt - rs;
    fe = (lvl == D);
    re = rdone && !fe;
    acc = v && re;
    chk("wr_ready", wr_ready, re);
    chk("mem_we", mem_we, acc);
    if (acc) begin
      chk("mem_waddr", mem_waddr, wr_cnt % D);
      chk("mem_wdata", mem_wdata, d);
    end
    chk("wr_level", wr_level, lvl);
    chk("full", full, fe);
    chk("almost_full", almost_full, lvl >= AF);
    chk("overflow", overflow, eovf);
    chk("wr_ptr_gray", wr_ptr_gray_o, g(wr_cnt));
    chk("gray_hamming", $countones(wr_ptr_gray_o ^ prev_g) <= 1, 1);
    prev_g = wr_ptr_gray_o;
`ifdef AFIFO_WR_ERRCNT_EN
    chk("ovf_cnt", ovf_cnt, eocnt);
    if (eovf && eocnt < 65535) eocnt++;
`endif
    tot_ovf += int'(overflow);
    full_seen += int'(full);
    if (acc && wr_cnt % D == 0 && wr_cnt > 0) wraps++;
    eovf = v && rdone && fe;
    wr_cnt += int'(acc);
    for (int i = S-1; i > 0; i--) rdp[i] = rdp[i-1];
    rdp[0] = rdb;
    rdone = 1;
    @(posedge wr_clk);
    @(negedge wr_clk);
  endtask

  task automatic do_reset;
    @(posedge wr_clk);
    #3;
    wr_valid = 1;
    wr_rst_n = 0;
    rd_ptr_gray_i = 0;
    model_reset;
    #1;
    chk_zero;
    @(negedge wr_clk);
    wr_rst_n = 1;
  endtask

  initial begin
    int rd;
    tbl[0] = '{55, 1, 0, 55, 0, 0, 1, 0, 55, 'h2C};
    tbl[1] = '{ 1, 1, 0, 56, 0, 1, 1, 0, 56, 'h24};
    tbl[2] = '{14, 1, 0, 64, 1, 1, 0, 1,  0, 'h60};
    tbl[3] = '{ 1, 0, 1, 64, 1, 1, 0, 0,  0, 'h60};
    tbl[4] = '{ 1, 0, 1, 63, 0, 1, 1, 0,  0, 'h60};
    tbl[5] = '{ 1, 1, 1, 64, 1, 1, 0, 0,  1, 'h61};
    model_reset;
    tot_ovf = 0; wraps = 0; full_seen = 0;
    wr_valid = 1;
    #1;
    chk_zero;
    @(negedge wr_clk);
    @(negedge wr_clk);
    wr_rst_n = 1;
    cyc(0, 0);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].v, tbl[i].rdb);
      #1;
      chk($sformatf("seg%0d_level", i), wr_level, tbl[i].lvl);
      chk($sformatf("seg%0d_full", i), full, tbl[i].f);
      chk($sformatf("seg%0d_afull", i), almost_full, tbl[i].af);
      chk($sformatf("seg%0d_ready", i), wr_ready, tbl[i].rdy);
      chk($sformatf("seg%0d_ovf", i), overflow, tbl[i].ovf);
      chk($sformatf("seg%0d_waddr", i), mem_waddr, tbl[i].waddr);
      chk($sformatf("seg%0d_gray", i), wr_ptr_gray_o, tbl[i].gr);
    end
    chk("overflow_pulses", tot_ovf, 6);

    do_reset;
    cyc(0, 0);
    wraps = 0; full_seen = 0;
    for (int i = 0; i < 200; i++) cyc(1, wr_cnt);
    chk("track_wraps", wraps, 3);
    chk("track_full_seen", full_seen, 0);

    do_reset;
    cyc(0, 0);
    rd = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) rd += int'($urandom_range(0, wr_cnt - rd));
      cyc($urandom_range(0, 3) != 0, rd);
    end

    do_reset;
    cyc(0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0);
    do_reset;
    cyc(1, 0);
    #1;
    chk("post_rst_ready", wr_ready, 1);
    chk("post_rst_waddr", mem_waddr, 0);
    cyc(1, 0);
    chk("post_rst_count", wr_cnt, 1);

`ifdef AFIFO_WR_ERRCNT_EN
    do_reset;
    cyc(0, 0);
    for (int i = 0; i < 64; i++) cyc(1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("ovf_cnt_5", ovf_cnt, 5);
    for (int i = 0; i < 70000; i++) cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("ovf_cnt_sat", ovf_cnt, 65535);
    do_reset;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
